// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: jump-control redirect, hazard stall, instruction ROM
// port and the IF/ID outputs toward decode.
interface pc_fetch_unit_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned IW = 20
);
   logic          pc_mux_sel;
   logic [AW-1:0] jmp_loc;
   logic          stall;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic [IW-1:0] ins;
   logic [AW-1:0] current_address;
   logic          ins_valid;

   // Fetch unit side
   modport master (
      input  pc_mux_sel, jmp_loc, stall, imem_data,
      output imem_addr, ins, current_address, ins_valid
   );

   // Environment side (jump control, hazard unit, ROM, decode)
   modport slave (
      output pc_mux_sel, jmp_loc, stall, imem_data,
      input  imem_addr, ins, current_address, ins_valid
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, synchronous ROM addressing and
// the IF/ID register. Redirects take priority over stalls; a redirect costs
// two bubbles before the target word reaches decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/flush counters.
module pc_fetch_unit #(
   parameter int unsigned   AW           = 8,
   parameter int unsigned   IW           = 20,
   parameter logic [AW-1:0] RESET_VECTOR = '0,
   parameter logic [IW-1:0] NOP_WORD     = '0
) (
   input  logic             clk,
   input  logic             reset,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]      fetch_cnt,
   output logic [15:0]      flush_cnt,
`endif
   pc_fetch_unit_if.master  bus
);

   logic [AW-1:0] pc_f;
   logic [AW-1:0] rsp_pc;
   logic          rsp_valid;
   logic [IW-1:0] ins_q;
   logic [AW-1:0] cur_addr_q;
   logic          ins_valid_q;

   // During a plain stall re-present the in-flight address so imem_data stays put.
   assign bus.imem_addr       = (bus.stall & ~bus.pc_mux_sel) ? rsp_pc : pc_f;
   assign bus.ins             = ins_q;
   assign bus.current_address = cur_addr_q;
   assign bus.ins_valid       = ins_valid_q;

   // PC, in-flight response tracking and IF/ID register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f        <= RESET_VECTOR;
         rsp_pc      <= RESET_VECTOR;
         rsp_valid   <= 1'b0;
         ins_q       <= NOP_WORD;
         cur_addr_q  <= RESET_VECTOR;
         ins_valid_q <= 1'b0;
      end else if (bus.pc_mux_sel) begin
         // Drop the in-flight word; decode sees a bubble tagged with the old PC.
         pc_f        <= bus.jmp_loc;
         rsp_valid   <= 1'b0;
         ins_q       <= NOP_WORD;
         ins_valid_q <= 1'b0;
      end else if (!bus.stall) begin
         if (rsp_valid) begin
            ins_q       <= bus.imem_data;
            cur_addr_q  <= rsp_pc;
            ins_valid_q <= 1'b1;
         end else begin
            ins_q       <= NOP_WORD;
            ins_valid_q <= 1'b0;
         end
         rsp_pc    <= pc_f;
         rsp_valid <= 1'b1;
         pc_f      <= pc_f + 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] flush_cnt_q;

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // Saturating counts of delivered instructions and discarded in-flight words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (bus.pc_mux_sel) begin
         if (rsp_valid && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end else if (!bus.stall && rsp_valid && fetch_cnt_q != 16'hFFFF) begin
         fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a registered ROM model ROM[a] = {12'hA00, a}.
module tb_pc_fetch_unit;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   pc_fetch_unit_if #(.AW(8), .IW(20)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt;
   logic [15:0] flush_cnt;
`endif

   pc_fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt (fetch_cnt),
      .flush_cnt (flush_cnt),
`endif
      .bus       (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered ROM
   always_ff @(posedge clk) bus.imem_data <= {12'hA00, bus.imem_addr};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.pc_mux_sel = 1'b0;
      bus.jmp_loc = 8'h00;
      bus.stall = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 20'h00000 || bus.current_address !== 8'h00) begin
         $display("FAIL reset_state: got v=%b ins=%h pc=%h, want v=0 ins=00000 pc=00",
                  bus.ins_valid, bus.ins, bus.current_address);
         n_bad++;
      end
      reset = 1'b0;
   endtask

   // Edge 1 after release is a bubble; then A0000..A0005.
   task automatic test_sequential();
      tick();
      n_cmp++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 20'h00000) begin
         $display("FAIL seq_first_bubble: got v=%b ins=%h, want v=0 ins=00000",
                  bus.ins_valid, bus.ins);
         n_bad++;
      end
      for (int k = 0; k < 6; k++) begin
         logic [7:0] a;
         a = k[7:0];
         tick();
         n_cmp++;
         if (bus.ins_valid !== 1'b1 || bus.ins !== {12'hA00, a} || bus.current_address !== a) begin
            $display("FAIL seq_%0d: got v=%b ins=%h pc=%h, want v=1 ins=%h pc=%h", k,
                     bus.ins_valid, bus.ins, bus.current_address, {12'hA00, a}, a);
            n_bad++;
         end
      end
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      #1;
      n_cmp++;
      if (bus.imem_addr !== 8'h06) begin
         $display("FAIL stall_addr: got %h want 06", bus.imem_addr);
         n_bad++;
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (bus.ins !== 20'hA0005 || bus.current_address !== 8'h05 || bus.ins_valid !== 1'b1
             || bus.imem_addr !== 8'h06) begin
            $display("FAIL stall_hold_%0d: got ins=%h pc=%h v=%b addr=%h, want A0005/05/1/06",
                     k, bus.ins, bus.current_address, bus.ins_valid, bus.imem_addr);
            n_bad++;
         end
      end
      bus.stall = 1'b0;
      for (int k = 6; k < 8; k++) begin
         logic [7:0] a;
         a = k[7:0];
         tick();
         n_cmp++;
         if (bus.ins !== {12'hA00, a} || bus.current_address !== a || bus.ins_valid !== 1'b1) begin
            $display("FAIL stall_release_%0d: got ins=%h pc=%h v=%b, want %h/%h/1", k,
                     bus.ins, bus.current_address, bus.ins_valid, {12'hA00, a}, a);
            n_bad++;
         end
      end
   endtask

   task automatic test_redirect();
      for (int k = 8; k <= 16; k++) tick();
      n_cmp++;
      if (bus.ins !== 20'hA0010 || bus.current_address !== 8'h10) begin
         $display("FAIL redir_pre: got ins=%h pc=%h, want A0010/10", bus.ins, bus.current_address);
         n_bad++;
      end
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc = 8'h40;
      tick();
      bus.pc_mux_sel = 1'b0;
      n_cmp++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 20'h00000 || bus.current_address !== 8'h10) begin
         $display("FAIL redir_bubble1: got v=%b ins=%h pc=%h, want 0/00000/10",
                  bus.ins_valid, bus.ins, bus.current_address);
         n_bad++;
      end
      tick();
      n_cmp++;
      if (bus.ins_valid !== 1'b0) begin
         $display("FAIL redir_bubble2: got v=%b want 0", bus.ins_valid);
         n_bad++;
      end
      for (int k = 0; k < 2; k++) begin
         logic [7:0] a;
         a = 8'h40 + k[7:0];
         tick();
         n_cmp++;
         if (bus.ins !== {12'hA00, a} || bus.current_address !== a || bus.ins_valid !== 1'b1) begin
            $display("FAIL redir_target_%0d: got ins=%h pc=%h v=%b, want %h/%h/1", k,
                     bus.ins, bus.current_address, bus.ins_valid, {12'hA00, a}, a);
            n_bad++;
         end
      end
   endtask

   task automatic test_back_to_back();
      // Redirect and stall on the same edge: redirect wins
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc = 8'h20;
      bus.stall = 1'b1;
      tick();
      bus.pc_mux_sel = 1'b0;
      bus.stall = 1'b0;
      tick();
      n_cmp++;
      if (bus.ins_valid !== 1'b0) begin
         $display("FAIL redir_stall_bubble: got v=%b want 0", bus.ins_valid);
         n_bad++;
      end
      tick();
      n_cmp++;
      if (bus.ins !== 20'hA0020 || bus.current_address !== 8'h20 || bus.ins_valid !== 1'b1) begin
         $display("FAIL redir_stall_target: got ins=%h pc=%h v=%b, want A0020/20/1",
                  bus.ins, bus.current_address, bus.ins_valid);
         n_bad++;
      end
      // Two redirects on consecutive edges: only the last target is fetched
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc = 8'h30;
      tick();
      bus.jmp_loc = 8'h50;
      tick();
      bus.pc_mux_sel = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (bus.ins_valid !== 1'b0) begin
            $display("FAIL b2b_bubble_%0d: got v=%b ins=%h, want v=0", k, bus.ins_valid, bus.ins);
            n_bad++;
         end
         tick();
      end
      n_cmp++;
      if (bus.ins !== 20'hA0050 || bus.current_address !== 8'h50 || bus.ins_valid !== 1'b1) begin
         $display("FAIL b2b_target: got ins=%h pc=%h v=%b, want A0050/50/1",
                  bus.ins, bus.current_address, bus.ins_valid);
         n_bad++;
      end
   endtask

   task automatic test_wrap();
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc = 8'hFE;
      tick();
      bus.pc_mux_sel = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] a;
         a = 8'hFE + k[7:0];
         tick();
         n_cmp++;
         if (bus.ins !== {12'hA00, a} || bus.current_address !== a || bus.ins_valid !== 1'b1) begin
            $display("FAIL wrap_%0d: got ins=%h pc=%h v=%b, want %h/%h/1", k,
                     bus.ins, bus.current_address, bus.ins_valid, {12'hA00, a}, a);
            n_bad++;
         end
      end
   endtask

   task automatic test_async_reset();
      bus.stall = 1'b1;
      tick();
      n_cmp++;
      if (bus.ins !== 20'hA0001 || bus.ins_valid !== 1'b1) begin
         $display("FAIL areset_pre: got ins=%h v=%b, want A0001/1", bus.ins, bus.ins_valid);
         n_bad++;
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.ins !== 20'h00000 || bus.ins_valid !== 1'b0 || bus.current_address !== 8'h00
          || bus.imem_addr !== 8'h00) begin
         $display("FAIL areset_immediate: got ins=%h v=%b pc=%h addr=%h, want 00000/0/00/00",
                  bus.ins, bus.ins_valid, bus.current_address, bus.imem_addr);
         n_bad++;
      end
      tick();
      reset = 1'b0;
      bus.stall = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (bus.ins !== 20'hA0000 || bus.current_address !== 8'h00 || bus.ins_valid !== 1'b1) begin
         $display("FAIL areset_restart: got ins=%h pc=%h v=%b, want A0000/00/1",
                  bus.ins, bus.current_address, bus.ins_valid);
         n_bad++;
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf_cnt();
      test_reset();
      n_cmp++;
      if (fetch_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         $display("FAIL perf_reset: got fetch=%0d flush=%0d, want 0/0", fetch_cnt, flush_cnt);
         n_bad++;
      end
      repeat (11) tick();
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc = 8'h80;
      tick();
      bus.pc_mux_sel = 1'b0;
      n_cmp++;
      if (fetch_cnt !== 16'd10 || flush_cnt !== 16'd1) begin
         $display("FAIL perf_count: got fetch=%0d flush=%0d, want 10/1", fetch_cnt, flush_cnt);
         n_bad++;
      end
      dut.fetch_cnt_q = 16'hFFFE;
      dut.flush_cnt_q = 16'hFFFF;
      repeat (4) tick();
      bus.pc_mux_sel = 1'b1;
      tick();
      bus.pc_mux_sel = 1'b0;
      n_cmp++;
      if (fetch_cnt !== 16'hFFFF || flush_cnt !== 16'hFFFF) begin
         $display("FAIL perf_saturate: got fetch=%h flush=%h, want FFFF/FFFF",
                  fetch_cnt, flush_cnt);
         n_bad++;
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_async_reset();
`ifdef FETCH_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
